kernel_cfg_ctrl: RTL

- Sequencer in front of the Gaussian kernel generator.
- Accepts kernel (sigma, size) configuration requests over a valid/ready handshake and validates them.
- Waits for the downstream convolution engine to go idle, pulses the generator start, and supervises completion with a timeout.
- Publishes kernel_valid and the latched normalisation sum to the convolution datapath.

---
 rtl/kernel_ctrl_pkg.sv | 22 ++
 rtl/kc_timeout_timer.sv | 37 +++
 rtl/kernel_cfg_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/kernel_ctrl_pkg.sv
// Shared types for the Gaussian kernel configuration sequencer.
// FSM states, error codes and kernel size limits.
package kernel_ctrl_pkg;

  typedef enum logic [2:0] {
    KC_IDLE,
    KC_VALIDATE,
    KC_DRAIN,
    KC_START,
    KC_GEN
  } kc_state_t;

  typedef enum logic [1:0] {
    KC_OK,
    KC_BAD_SIZE,
    KC_BAD_SIGMA,
    KC_TIMEOUT
  } kc_err_t;

  localparam int MIN_KERNEL = 3;

endpackage

// File: rtl/kc_timeout_timer.sv
// Clear/enable cycle counter flagging the last cycle of the
// generator time budget.
module kc_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 128
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // saturates once expired so a stalled FSM cannot wrap it
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/kernel_cfg_ctrl.sv
// Validates kernel (sigma, size) requests, sequences the generator
// around the convolution engine and publishes the kernel sum.
module kernel_cfg_ctrl
  import kernel_ctrl_pkg::*;
#(
  parameter int MAX_KERNAL     = 7,
  parameter int TIMEOUT_CYCLES = 128
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [2:0]                    cfg_sigma,
  input  logic [$clog2(MAX_KERNAL)-1:0] cfg_size,
  output logic                          cfg_done,
  output logic                          cfg_err,
  output logic [1:0]                    cfg_err_code,
  input  logic                          conv_busy,
  output logic                          gen_start,
  output logic [2:0]                    gen_sigma,
  output logic [$clog2(MAX_KERNAL)-1:0] gen_size,
  input  logic                          gen_done,
  input  logic [31:0]                   gen_sum,
  output logic                          kernel_valid,
  output logic [31:0]                   kernel_sum
);

  localparam int SW = $clog2(MAX_KERNAL);

  kc_state_t       state_q, state_d;
  kc_err_t         code_q, code_d;
  logic [2:0]      req_sig_q, req_sig_d;
  logic [SW-1:0]   req_sz_q, req_sz_d;
  logic [2:0]      gsig_q, gsig_d;
  logic [SW-1:0]   gsz_q, gsz_d;
  logic [31:0]     ksum_q, ksum_d;
  logic            kv_q, kv_d;
  logic            rdy_q, rdy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            start_q, start_d;
  logic            tmr_clr, tmr_en, tmr_exp;
  logic            size_bad, same_req;

  kc_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (tmr_clr),
    .en     (tmr_en),
    .expired(tmr_exp)
  );

  assign size_bad = !req_sz_q[0]
                 || (32'(req_sz_q) < MIN_KERNEL)
                 || (32'(req_sz_q) > MAX_KERNAL);
  assign same_req = (req_sig_q == gsig_q)
                 && (req_sz_q == gsz_q);

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    req_sig_d = req_sig_q;
    req_sz_d  = req_sz_q;
    gsig_d    = gsig_q;
    gsz_d     = gsz_q;
    ksum_d    = ksum_q;
    kv_d      = kv_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    start_d   = 1'b0;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    unique case (state_q)
      KC_IDLE: begin
        if (cfg_valid && rdy_q) begin
          req_sig_d = cfg_sigma;
          req_sz_d  = cfg_size;
          code_d    = KC_OK;
          state_d   = KC_VALIDATE;
        end
      end
      KC_VALIDATE: begin
        state_d = KC_IDLE;
        if (size_bad) begin
          err_d  = 1'b1;
          code_d = KC_BAD_SIZE;
        end else if (req_sig_q == 3'd0) begin
          err_d  = 1'b1;
          code_d = KC_BAD_SIGMA;
        end else if (kv_q && same_req) begin
          done_d = 1'b1;
        end else begin
          kv_d    = 1'b0;
          state_d = KC_DRAIN;
        end
      end
      KC_DRAIN: begin
        gsig_d = req_sig_q;
        gsz_d  = req_sz_q;
        if (!conv_busy) state_d = KC_START;
      end
      KC_START: begin
        start_d = 1'b1;
        tmr_clr = 1'b1;
        state_d = KC_GEN;
      end
      KC_GEN: begin
        tmr_en = 1'b1;
        // a completion on the final budget cycle still counts
        if (gen_done) begin
          ksum_d  = gen_sum;
          kv_d    = 1'b1;
          done_d  = 1'b1;
          state_d = KC_IDLE;
        end else if (tmr_exp) begin
          err_d   = 1'b1;
          code_d  = KC_TIMEOUT;
          state_d = KC_IDLE;
        end
      end
      default: state_d = KC_IDLE;
    endcase
    rdy_d = (state_d == KC_IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= KC_IDLE;
      code_q    <= KC_OK;
      req_sig_q <= '0;
      req_sz_q  <= '0;
      gsig_q    <= '0;
      gsz_q     <= '0;
      ksum_q    <= '0;
      kv_q      <= 1'b0;
      rdy_q     <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      req_sig_q <= req_sig_d;
      req_sz_q  <= req_sz_d;
      gsig_q    <= gsig_d;
      gsz_q     <= gsz_d;
      ksum_q    <= ksum_d;
      kv_q      <= kv_d;
      rdy_q     <= rdy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      start_q   <= start_d;
    end
  end

  assign cfg_ready    = rdy_q;
  assign cfg_done     = done_q;
  assign cfg_err      = err_q;
  assign cfg_err_code = code_q;
  assign gen_start    = start_q;
  assign gen_sigma    = gsig_q;
  assign gen_size     = gsz_q;
  assign kernel_valid = kv_q;
  assign kernel_sum   = ksum_q;

endmodule
